snake_body_ctrl: RTL and testbench



---
 rtl/snake_pkg.sv | 26 ++
 rtl/snake_seg_store.sv | 56 +++++
 rtl/snake_body_ctrl.sv | 161 ++++++++++++++++
 tb/tb_snake_body_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared types and default grid constants for the snake game datapath.
// The direction encoding is common to the direction FSM and the body controller.
package snake_pkg;

   typedef enum logic [2:0] {
      STOP  = 3'd0,
      LEFT  = 3'd1,
      RIGHT = 3'd2,
      UP    = 3'd3,
      DOWN  = 3'd4
   } direction_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CHECK  = 2'd1,
      UPDATE = 2'd2,
      DEAD   = 2'd3
   } ctrl_state_t;

   localparam int GRID_W_DEF  = 16;
   localparam int GRID_H_DEF  = 12;
   localparam int MAX_LEN_DEF = 16;
   localparam int X_W_DEF     = $clog2(GRID_W_DEF);
   localparam int Y_W_DEF     = $clog2(GRID_H_DEF);

endpackage

// File: rtl/snake_seg_store.sv
// Snake body coordinate shift register: segment 0 is the head, shift-in on update.
// Two combinational read ports serve the collision checker and the renderer.
module snake_seg_store
   import snake_pkg::*;
#(
   parameter int MAX_LEN  = 16,
   parameter int INIT_LEN = 3,
   parameter int START_X  = 8,
   parameter int START_Y  = 6,
   parameter int XW       = 4,
   parameter int YW       = 4,
   parameter int IW       = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_shift,
   input  logic [XW-1:0] i_head_x,
   input  logic [YW-1:0] i_head_y,
   input  logic [IW-1:0] i_chk_idx,
   input  logic [IW-1:0] i_rd_idx,
   output logic [XW-1:0] o_chk_x,
   output logic [YW-1:0] o_chk_y,
   output logic [XW-1:0] o_rd_x,
   output logic [YW-1:0] o_rd_y,
   output logic [XW-1:0] o_seg0_x,
   output logic [YW-1:0] o_seg0_y
);

   logic [XW-1:0] r_x [MAX_LEN];
   logic [YW-1:0] r_y [MAX_LEN];

   // Reset lays the initial body out horizontally, trailing to the left of the head.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < MAX_LEN; i++) begin
            r_x[i] <= (i < INIT_LEN) ? XW'(START_X - i) : '0;
            r_y[i] <= (i < INIT_LEN) ? YW'(START_Y) : '0;
         end
      end else if (i_shift) begin
         r_x[0] <= i_head_x;
         r_y[0] <= i_head_y;
         for (int i = 1; i < MAX_LEN; i++) begin
            r_x[i] <= r_x[i-1];
            r_y[i] <= r_y[i-1];
         end
      end
   end

   assign o_chk_x  = r_x[i_chk_idx];
   assign o_chk_y  = r_y[i_chk_idx];
   assign o_rd_x   = r_x[i_rd_idx];
   assign o_rd_y   = r_y[i_rd_idx];
   assign o_seg0_x = r_x[0];
   assign o_seg0_y = r_y[0];

endmodule

// File: rtl/snake_body_ctrl.sv
// Per-tick snake body sequencer: next-head computation, wall and self-collision
// scan (one segment per cycle), then body shift with optional growth.
module snake_body_ctrl
   import snake_pkg::*;
#(
   parameter int GRID_W   = 16,
   parameter int GRID_H   = 12,
   parameter int MAX_LEN  = 16,
   parameter int INIT_LEN = 3,
   parameter int START_X  = 8,
   parameter int START_Y  = 6
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         pulse,
   input  direction_t                   direction,
   input  logic [$clog2(GRID_W)-1:0]    apple_x,
   input  logic [$clog2(GRID_H)-1:0]    apple_y,
   input  logic [$clog2(MAX_LEN)-1:0]   rd_idx,
   output logic [$clog2(GRID_W)-1:0]    rd_x,
   output logic [$clog2(GRID_H)-1:0]    rd_y,
   output logic                         rd_valid,
   output logic [$clog2(GRID_W)-1:0]    head_x,
   output logic [$clog2(GRID_H)-1:0]    head_y,
   output logic [$clog2(MAX_LEN+1)-1:0] length,
   output logic                         eaten,
   output logic                         busy,
   output logic                         game_over
);

   localparam int XW = $clog2(GRID_W);
   localparam int YW = $clog2(GRID_H);
   localparam int IW = $clog2(MAX_LEN);
   localparam int LW = $clog2(MAX_LEN+1);

   ctrl_state_t   r_state;
   logic [XW-1:0] r_nh_x;
   logic [YW-1:0] r_nh_y;
   logic          r_grow;
   logic [IW-1:0] r_idx;
   logic [LW-1:0] r_len;
   logic          r_eaten;
   logic          r_game_over;

   logic [XW-1:0] w_head_x, w_chk_x, w_nh_x;
   logic [YW-1:0] w_head_y, w_chk_y, w_nh_y;
   logic          w_wall, w_move, w_hit;
   logic [LW-1:0] w_limit;

   snake_seg_store #(
      .MAX_LEN (MAX_LEN),
      .INIT_LEN(INIT_LEN),
      .START_X (START_X),
      .START_Y (START_Y),
      .XW      (XW),
      .YW      (YW),
      .IW      (IW)
   ) u_store (
      .clk      (clk),
      .rst      (rst),
      .i_shift  (r_state == UPDATE),
      .i_head_x (r_nh_x),
      .i_head_y (r_nh_y),
      .i_chk_idx(r_idx),
      .i_rd_idx (rd_idx),
      .o_chk_x  (w_chk_x),
      .o_chk_y  (w_chk_y),
      .o_rd_x   (rd_x),
      .o_rd_y   (rd_y),
      .o_seg0_x (w_head_x),
      .o_seg0_y (w_head_y)
   );

   // Undefined direction codes are treated like STOP rather than as a move.
   always_comb begin
      w_nh_x = w_head_x;
      w_nh_y = w_head_y;
      w_wall = 1'b0;
      w_move = 1'b1;
      case (direction)
         LEFT: begin
            w_wall = (w_head_x == '0);
            w_nh_x = w_head_x - XW'(1);
         end
         RIGHT: begin
            w_wall = (w_head_x == XW'(GRID_W-1));
            w_nh_x = w_head_x + XW'(1);
         end
         UP: begin
            w_wall = (w_head_y == '0);
            w_nh_y = w_head_y - YW'(1);
         end
         DOWN: begin
            w_wall = (w_head_y == YW'(GRID_H-1));
            w_nh_y = w_head_y + YW'(1);
         end
         default: w_move = 1'b0;
      endcase
   end

   // Without growth the tail cell is vacated this tick, so the scan stops short of it.
   assign w_limit = r_grow ? (r_len - LW'(1)) : (r_len - LW'(2));
   assign w_hit   = (w_chk_x == r_nh_x) && (w_chk_y == r_nh_y);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_nh_x      <= '0;
         r_nh_y      <= '0;
         r_grow      <= 1'b0;
         r_idx       <= '0;
         r_len       <= LW'(INIT_LEN);
         r_eaten     <= 1'b0;
         r_game_over <= 1'b0;
      end else begin
         r_eaten <= 1'b0;
         case (r_state)
            IDLE: begin
               if (pulse && w_move) begin
                  if (w_wall) begin
                     r_state     <= DEAD;
                     r_game_over <= 1'b1;
                  end else begin
                     r_nh_x  <= w_nh_x;
                     r_nh_y  <= w_nh_y;
                     r_grow  <= (w_nh_x == apple_x) && (w_nh_y == apple_y);
                     r_idx   <= '0;
                     r_state <= CHECK;
                  end
               end
            end
            CHECK: begin
               if (w_hit) begin
                  r_state     <= DEAD;
                  r_game_over <= 1'b1;
               end else if (LW'(r_idx) == w_limit) begin
                  r_state <= UPDATE;
                  r_eaten <= r_grow;
               end else begin
                  r_idx <= r_idx + IW'(1);
               end
            end
            UPDATE: begin
               if (r_grow && (r_len < LW'(MAX_LEN)))
                  r_len <= r_len + LW'(1);
               r_state <= IDLE;
            end
            default: r_state <= DEAD;
         endcase
      end
   end

   assign head_x    = w_head_x;
   assign head_y    = w_head_y;
   assign length    = r_len;
   assign eaten     = r_eaten;
   assign game_over = r_game_over;
   assign busy      = (r_state == CHECK) || (r_state == UPDATE);
   assign rd_valid  = (LW'(rd_idx) < r_len);

endmodule

// File: tb/tb_snake_body_ctrl.sv
// Directed scenario bench for snake_body_ctrl using the default 16x12 grid.
module tb_snake_body_ctrl;
   import snake_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       pulse = 1'b0;
   direction_t direction = STOP;
   logic [3:0] apple_x = '0;
   logic [3:0] apple_y = '0;
   logic [3:0] rd_idx = '0;
   logic [3:0] rd_x, rd_y, head_x, head_y;
   logic       rd_valid, eaten, busy, game_over;
   logic [4:0] length;

   int n_tests = 0;
   int n_fail  = 0;
   int busy_cyc, eat_cyc;

   snake_body_ctrl dut (
      .clk(clk), .rst(rst), .pulse(pulse), .direction(direction),
      .apple_x(apple_x), .apple_y(apple_y), .rd_idx(rd_idx),
      .rd_x(rd_x), .rd_y(rd_y), .rd_valid(rd_valid),
      .head_x(head_x), .head_y(head_y), .length(length),
      .eaten(eaten), .busy(busy), .game_over(game_over)
   );

   always #5 clk = ~clk;

   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      cyc(1);
   endtask

   task automatic do_pulse(input direction_t d);
      direction = d;
      pulse = 1'b1;
      cyc(1);
      pulse = 1'b0;
      direction = STOP;
   endtask

   // Counts busy cycles and eaten strobes until the controller leaves CHECK/UPDATE.
   task automatic wait_idle();
      busy_cyc = 0;
      eat_cyc  = 0;
      while (busy && busy_cyc < 50) begin
         if (eaten) eat_cyc++;
         cyc(1);
         busy_cyc++;
      end
      if (eaten) eat_cyc++;
   endtask

   task automatic move(input direction_t d);
      do_pulse(d);
      wait_idle();
   endtask

   task automatic test_reset();
      do_reset();
      n_tests++; if (length !== 5'd3) begin n_fail++; $display("FAIL reset_len got %0d want 3", length); end
      n_tests++; if ({head_x, head_y} !== {4'd8, 4'd6}) begin n_fail++; $display("FAIL reset_head got (%0d,%0d) want (8,6)", head_x, head_y); end
      rd_idx = 4'd1; #1;
      n_tests++; if ({rd_valid, rd_x, rd_y} !== {1'b1, 4'd7, 4'd6}) begin n_fail++; $display("FAIL reset_seg1 got v%0d (%0d,%0d) want v1 (7,6)", rd_valid, rd_x, rd_y); end
      rd_idx = 4'd2; #1;
      n_tests++; if ({rd_valid, rd_x, rd_y} !== {1'b1, 4'd6, 4'd6}) begin n_fail++; $display("FAIL reset_seg2 got v%0d (%0d,%0d) want v1 (6,6)", rd_valid, rd_x, rd_y); end
      rd_idx = 4'd3; #1;
      n_tests++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_seg3_valid got %0d want 0", rd_valid); end
      n_tests++; if ({game_over, busy, eaten} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got go%0d busy%0d eaten%0d want 000", game_over, busy, eaten); end
      rd_idx = 4'd0;
   endtask

   task automatic test_move();
      do_reset();
      apple_x = 4'd0; apple_y = 4'd0;
      move(RIGHT);
      n_tests++; if (busy_cyc !== 3) begin n_fail++; $display("FAIL move_busy got %0d want 3", busy_cyc); end
      n_tests++; if (eat_cyc !== 0) begin n_fail++; $display("FAIL move_eaten got %0d want 0", eat_cyc); end
      n_tests++; if ({head_x, head_y, length} !== {4'd9, 4'd6, 5'd3}) begin n_fail++; $display("FAIL move_head got (%0d,%0d) len %0d want (9,6) len 3", head_x, head_y, length); end
      rd_idx = 4'd1; #1;
      n_tests++; if ({rd_x, rd_y} !== {4'd8, 4'd6}) begin n_fail++; $display("FAIL move_seg1 got (%0d,%0d) want (8,6)", rd_x, rd_y); end
      rd_idx = 4'd2; #1;
      n_tests++; if ({rd_x, rd_y} !== {4'd7, 4'd6}) begin n_fail++; $display("FAIL move_seg2 got (%0d,%0d) want (7,6)", rd_x, rd_y); end
      rd_idx = 4'd0;
   endtask

   task automatic test_eat();
      do_reset();
      apple_x = 4'd9; apple_y = 4'd6;
      move(RIGHT);
      n_tests++; if (busy_cyc !== 4) begin n_fail++; $display("FAIL eat_busy got %0d want 4", busy_cyc); end
      n_tests++; if (eat_cyc !== 1) begin n_fail++; $display("FAIL eat_strobe got %0d want 1", eat_cyc); end
      n_tests++; if ({head_x, head_y, length} !== {4'd9, 4'd6, 5'd4}) begin n_fail++; $display("FAIL eat_head got (%0d,%0d) len %0d want (9,6) len 4", head_x, head_y, length); end
      rd_idx = 4'd3; #1;
      n_tests++; if ({rd_valid, rd_x, rd_y} !== {1'b1, 4'd6, 4'd6}) begin n_fail++; $display("FAIL eat_tail got v%0d (%0d,%0d) want v1 (6,6)", rd_valid, rd_x, rd_y); end
      rd_idx = 4'd0;
   endtask

   task automatic test_wall();
      do_reset();
      apple_x = 4'd0; apple_y = 4'd0;
      for (int i = 0; i < 7; i++) move(RIGHT);
      n_tests++; if ({head_x, game_over} !== {4'd15, 1'b0}) begin n_fail++; $display("FAIL wall_edge got x%0d go%0d want x15 go0", head_x, game_over); end
      do_pulse(RIGHT);
      n_tests++; if ({game_over, busy} !== 2'b10) begin n_fail++; $display("FAIL wall_death got go%0d busy%0d want go1 busy0", game_over, busy); end
      do_pulse(LEFT);
      cyc(5);
      do_pulse(DOWN);
      cyc(5);
      n_tests++; if ({head_x, head_y, length, game_over} !== {4'd15, 4'd6, 5'd3, 1'b1}) begin n_fail++; $display("FAIL wall_frozen got (%0d,%0d) len %0d go%0d want (15,6) len 3 go1", head_x, head_y, length, game_over); end
   endtask

   task automatic test_self_collision();
      do_reset();
      apple_x = 4'd9;  apple_y = 4'd6; move(RIGHT);
      apple_x = 4'd10; apple_y = 4'd6; move(RIGHT);
      n_tests++; if ({head_x, head_y, length} !== {4'd10, 4'd6, 5'd5}) begin n_fail++; $display("FAIL self_setup got (%0d,%0d) len %0d want (10,6) len 5", head_x, head_y, length); end
      apple_x = 4'd0; apple_y = 4'd0;
      move(DOWN);
      n_tests++; if ({head_x, head_y} !== {4'd10, 4'd7}) begin n_fail++; $display("FAIL self_down got (%0d,%0d) want (10,7)", head_x, head_y); end
      move(LEFT);
      n_tests++; if ({head_x, head_y} !== {4'd9, 4'd7}) begin n_fail++; $display("FAIL self_left got (%0d,%0d) want (9,7)", head_x, head_y); end
      move(UP);
      n_tests++; if ({game_over, head_x, head_y, length} !== {1'b1, 4'd9, 4'd7, 5'd5}) begin n_fail++; $display("FAIL self_hit got go%0d (%0d,%0d) len %0d want go1 (9,7) len 5", game_over, head_x, head_y, length); end
   endtask

   task automatic test_tail_chase();
      do_reset();
      apple_x = 4'd9; apple_y = 4'd6; move(RIGHT);
      apple_x = 4'd0; apple_y = 4'd0;
      move(DOWN);
      move(LEFT);
      move(UP);
      move(RIGHT);
      n_tests++; if ({game_over, head_x, head_y, length} !== {1'b0, 4'd9, 4'd6, 5'd4}) begin n_fail++; $display("FAIL tail_chase got go%0d (%0d,%0d) len %0d want go0 (9,6) len 4", game_over, head_x, head_y, length); end
      rd_idx = 4'd3; #1;
      n_tests++; if ({rd_x, rd_y} !== {4'd9, 4'd7}) begin n_fail++; $display("FAIL tail_chase_seg3 got (%0d,%0d) want (9,7)", rd_x, rd_y); end
      rd_idx = 4'd0;
   endtask

   task automatic test_back_to_back();
      do_reset();
      apple_x = 4'd0; apple_y = 4'd0;
      do_pulse(RIGHT);
      do_pulse(UP);
      wait_idle();
      cyc(6);
      n_tests++; if ({head_x, head_y, busy} !== {4'd9, 4'd6, 1'b0}) begin n_fail++; $display("FAIL busy_drop got (%0d,%0d) busy%0d want (9,6) busy0", head_x, head_y, busy); end
      do_pulse(STOP);
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stop_busy got %0d want 0", busy); end
      cyc(5);
      n_tests++; if ({head_x, head_y, length} !== {4'd9, 4'd6, 5'd3}) begin n_fail++; $display("FAIL stop_nochange got (%0d,%0d) len %0d want (9,6) len 3", head_x, head_y, length); end
   endtask

   task automatic test_reset_mid_check();
      do_reset();
      apple_x = 4'd9; apple_y = 4'd6;
      do_pulse(RIGHT);
      n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midrst_busy_before got %0d want 1", busy); end
      rst = 1'b1;
      #1;
      n_tests++; if ({busy, head_x, head_y, length, game_over} !== {1'b0, 4'd8, 4'd6, 5'd3, 1'b0}) begin n_fail++; $display("FAIL midrst_state got busy%0d (%0d,%0d) len %0d go%0d want busy0 (8,6) len 3 go0", busy, head_x, head_y, length, game_over); end
      cyc(1);
      rst = 1'b0;
      cyc(5);
      n_tests++; if ({busy, head_x, length} !== {1'b0, 4'd8, 5'd3}) begin n_fail++; $display("FAIL midrst_after got busy%0d x%0d len %0d want busy0 x8 len 3", busy, head_x, length); end
   endtask

   initial begin
      test_reset();
      test_move();
      test_eat();
      test_wall();
      test_self_collision();
      test_tail_chase();
      test_back_to_back();
      test_reset_mid_check();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
